// File: rtl/montgomery_mul_seq_if.sv
// Operand/result bus for montgomery_mul_seq.
//
// Handshake: on both sides a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds its payload stable while
// valid is high. The consumer may lower ready at any time. The block drives
// in_ready and out_valid only from registers, so ready never depends
// combinationally on valid.
interface montgomery_mul_seq_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] n;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             err;

   // Operand sequencer / result consumer side.
   modport master (
      output in_valid, a, b, n, out_ready,
      input  in_ready, out_valid, result, err
   );

   // Multiplier side.
   modport slave (
      input  in_valid, a, b, n, out_ready,
      output in_ready, out_valid, result, err
   );
endinterface

// File: rtl/montgomery_mul_seq.sv
// montgomery_mul_seq: bit-serial radix-2 Montgomery multiplier.
// result = a*b*2^-WIDTH mod n, with a runtime modulus, valid/ready on both
// sides and a synchronous active-high reset.
// Optional build macro MONTGOMERY_RANGE_CHECK_EN: rejects even n, a >= n or
// b >= n at acceptance and answers at once with err=1, result=0.
// dbg_state exposes the FSM state (0 IDLE, 1 CALC, 2 FINAL, 3 DONE).
module montgomery_mul_seq #(
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   montgomery_mul_seq_if.slave        bus,
   output logic [1:0]                 dbg_state
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] n_r;
   logic [WIDTH-1:0] result_r;
   // S stays below 2n and T below 4n, so two guard bits cover WIDTH=64 with
   // n close to 2^64.
   logic [WIDTH+1:0] s_r;
   logic [WIDTH+1:0] n_ext;
   logic [WIDTH+1:0] t_add;
   logic [WIDTH+1:0] t_odd;
   logic [WIDTH+1:0] s_nx;
   logic [WIDTH-1:0] s_red;
   logic [CW-1:0]    i_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             accept;

   // in_ready_r is only ever 1 while in IDLE, so it alone qualifies acceptance.
   assign accept = bus.in_valid & in_ready_r;

`ifdef MONTGOMERY_RANGE_CHECK_EN
   logic err_r;
   logic bad_in;
   assign bad_in  = ~bus.n[0] | (bus.a >= bus.n) | (bus.b >= bus.n);
   assign bus.err = err_r;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign dbg_state     = state;

   // One radix-2 step: add b if the current bit of a is set, make the sum even
   // by adding n, then halve. Also the final conditional subtraction.
   always_comb begin
      n_ext = {2'b00, n_r};
      t_add = s_r + (a_r[i_r] ? {2'b00, b_r} : '0);
      t_odd = t_add[0] ? (t_add + n_ext) : t_add;
      s_nx  = t_odd >> 1;
      s_red = WIDTH'((s_r >= n_ext) ? (s_r - n_ext) : s_r);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = CALC;
`ifdef MONTGOMERY_RANGE_CHECK_EN
               if (bad_in) state_nx = DONE;
`endif
            end
         end
         CALC:    if (i_r == CW'(WIDTH - 1)) state_nx = FINAL;
         FINAL:   state_nx = DONE;
         DONE:    if (out_valid_r & bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch, serial accumulator, result and handshake flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r         <= '0;
         b_r         <= '0;
         n_r         <= '0;
         s_r         <= '0;
         i_r         <= '0;
         result_r    <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
`ifdef MONTGOMERY_RANGE_CHECK_EN
         err_r       <= 1'b0;
`endif
      end else begin
         in_ready_r <= (state_nx == IDLE);
         case (state)
            IDLE: begin
               if (accept) begin
                  a_r <= bus.a;
                  b_r <= bus.b;
                  n_r <= bus.n;
                  s_r <= '0;
                  i_r <= '0;
`ifdef MONTGOMERY_RANGE_CHECK_EN
                  err_r <= bad_in;
                  if (bad_in) begin
                     result_r    <= '0;
                     out_valid_r <= 1'b1;
                  end
`endif
               end
            end
            CALC: begin
               s_r <= s_nx;
               i_r <= i_r + CW'(1);
            end
            FINAL: begin
               result_r    <= s_red;
               out_valid_r <= 1'b1;
            end
            DONE: begin
               if (out_valid_r & bus.out_ready) out_valid_r <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_montgomery_mul_seq.sv
// Bench for montgomery_mul_seq: an 8-bit and a 64-bit instance checked
// against a modular-arithmetic model (a*b mod n, then halved mod n WIDTH
// times), with per-cycle output, latency and in_ready checks.
module tb_montgomery_mul_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   montgomery_mul_seq_if #(.WIDTH(8))  bus8 ();
   montgomery_mul_seq_if #(.WIDTH(64)) bus64 ();
   logic [1:0] dbg8;
   logic [1:0] dbg64;

   montgomery_mul_seq #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .bus(bus8.slave), .dbg_state(dbg8)
   );
   montgomery_mul_seq #(.WIDTH(64)) u64 (
      .clk(clk), .rst(rst), .bus(bus64.slave), .dbg_state(dbg64)
   );

   int nvec = 0;
   int nmis = 0;
   int cyc  = 0;
   int acc8 = 0;
   int acc64 = 0;
   int or_mode = 0;
   bit rst_q = 1'b1;
   bit busy8 = 1'b0;
   bit busy64 = 1'b0;
   bit ov8_prev = 1'b0;
   bit ov64_prev = 1'b0;
   // Scoreboard entries: {dont_care_result, err, result}
   logic [65:0] exp8_q[$];
   logic [65:0] exp64_q[$];
   int          acc64_q[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // a*b*R^-1 mod n: reduce the plain product, then divide by 2 mod n w times.
   function automatic logic [63:0] mont_ref(input logic [63:0] a, b, n, input int w);
      logic [129:0] x;
      x = ({66'd0, a} * {66'd0, b}) % {66'd0, n};
      for (int k = 0; k < w; k++) x = x[0] ? ((x + {66'd0, n}) >> 1) : (x >> 1);
      return x[63:0];
   endfunction

   function automatic logic [65:0] expect_of(input logic [63:0] a, b, n, input int w);
      bit bad;
      bad = (n[0] == 1'b0) || (a >= n) || (b >= n);
`ifdef MONTGOMERY_RANGE_CHECK_EN
      if (bad) return {2'b01, 64'd0};
`else
      if (bad) return {2'b10, 64'd0};
`endif
      return {2'b00, mont_ref(a, b, n, w)};
   endfunction

   // Consumer back-pressure pattern.
   always @(negedge clk) begin
      case (or_mode)
         0:       begin bus8.out_ready = 1'b1; bus64.out_ready = 1'b1; end
         1:       begin bus8.out_ready = 1'($urandom_range(0, 1)); bus64.out_ready = 1'($urandom_range(0, 1)); end
         default: begin bus8.out_ready = 1'b0; bus64.out_ready = 1'b0; end
      endcase
   end

   // Edge monitor: records what the DUT sampled at this edge.
   always @(posedge clk) begin
      rst_q = rst;
      if (rst) begin
         exp8_q.delete();
         exp64_q.delete();
         busy8 = 1'b0;
         busy64 = 1'b0;
      end else begin
         if (bus8.in_valid && bus8.in_ready) begin
            exp8_q.push_back(expect_of(64'(bus8.a), 64'(bus8.b), 64'(bus8.n), 8));
            acc8 = cyc;
            busy8 = 1'b1;
         end
         if (bus8.out_valid && bus8.out_ready) begin
            if (exp8_q.size() > 0) void'(exp8_q.pop_front());
            busy8 = 1'b0;
         end
         if (bus64.in_valid && bus64.in_ready) begin
            exp64_q.push_back(expect_of(bus64.a, bus64.b, bus64.n, 64));
            acc64 = cyc;
            acc64_q.push_back(cyc);
            busy64 = 1'b1;
         end
         if (bus64.out_valid && bus64.out_ready) begin
            if (exp64_q.size() > 0) void'(exp64_q.pop_front());
            busy64 = 1'b0;
         end
      end
      cyc++;
   end

   // Compare process: checks both DUTs every cycle, mid-way between edges.
   always @(negedge clk) begin
      logic [65:0] e;
      if (rst_q) begin
         chk("rst in_ready8", 64'(bus8.in_ready), 64'd0);
         chk("rst out_valid8", 64'(bus8.out_valid), 64'd0);
         chk("rst result8", 64'(bus8.result), 64'd0);
         chk("rst err8", 64'(bus8.err), 64'd0);
         chk("rst in_ready64", 64'(bus64.in_ready), 64'd0);
         chk("rst out_valid64", 64'(bus64.out_valid), 64'd0);
         chk("rst result64", bus64.result, 64'd0);
      end else begin
         chk("in_ready8", 64'(bus8.in_ready), 64'(!busy8));
         if (bus8.out_valid === 1'b1) begin
            chk("out_valid8 expected", 64'd1, 64'(exp8_q.size() != 0));
            if (exp8_q.size() != 0) begin
               e = exp8_q[0];
               chk("err8", 64'(bus8.err), 64'(e[64]));
               if (!e[65]) chk("result8", 64'(bus8.result), e[63:0]);
               if (!ov8_prev) chk("latency8", 64'(cyc - 1 - acc8), e[64] ? 64'd1 : 64'd9);
            end
         end
         chk("in_ready64", 64'(bus64.in_ready), 64'(!busy64));
         if (bus64.out_valid === 1'b1) begin
            chk("out_valid64 expected", 64'd1, 64'(exp64_q.size() != 0));
            if (exp64_q.size() != 0) begin
               e = exp64_q[0];
               chk("err64", 64'(bus64.err), 64'(e[64]));
               if (!e[65]) chk("result64", bus64.result, e[63:0]);
               if (!ov64_prev) chk("latency64", 64'(cyc - 1 - acc64), e[64] ? 64'd1 : 64'd65);
            end
         end
      end
      ov8_prev = (bus8.out_valid === 1'b1);
      ov64_prev = (bus64.out_valid === 1'b1);
   end

   // Driver: present an operation from a negedge and return at the negedge
   // after the accepting edge. in_valid is dropped there, so a following call
   // made at once keeps the request continuous.
   task automatic issue(input bit wide, input logic [63:0] a, b, n);
      int guard = 0;
      if (wide) begin
         bus64.a = a; bus64.b = b; bus64.n = n; bus64.in_valid = 1'b1;
      end else begin
         bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.n = n[7:0]; bus8.in_valid = 1'b1;
      end
      while (!(wide ? bus64.in_ready : bus8.in_ready) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) begin
         nvec++; nmis++;
         $display("FAIL issue timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
      end
      @(negedge clk);
      if (wide) bus64.in_valid = 1'b0;
      else bus8.in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit wide);
      int guard = 0;
      while ((wide ? busy64 : busy8) && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 3000) begin
         nvec++; nmis++;
         $display("FAIL wait_done timeout: busy after %0d cycles, required idle", guard);
      end
      @(negedge clk);
   endtask

   task automatic rand_op(input bit wide);
      logic [63:0] a, b, n;
      int unsigned nn;
      if (!wide) begin
         nn = $urandom_range(3, 255) | 1;
         n = 64'(nn);
         a = 64'($urandom_range(0, nn - 1));
         b = 64'($urandom_range(0, nn - 1));
      end else begin
         n = {$urandom, $urandom} | 64'd1;
         if ($urandom_range(0, 1) == 1) n[63:56] = 8'hFF;
         if (n < 64'd3) n = 64'd3;
         a = {$urandom, $urandom} % n;
         b = {$urandom, $urandom} % n;
      end
      issue(wide, a, b, n);
   endtask

   initial begin
      bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.n = '0;
      bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.n = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Hand-computed anchors for the model (n=97, R=256, R^-1 mod 97 = 36).
      chk("model 5*7", mont_ref(64'd5, 64'd7, 64'd97, 8), 64'd96);
      chk("model 1*1", mont_ref(64'd1, 64'd1, 64'd97, 8), 64'd36);
      chk("model 62*50", mont_ref(64'd62, 64'd50, 64'd97, 8), 64'd50);
      chk("model 0*55", mont_ref(64'd0, 64'd55, 64'd97, 8), 64'd0);
      chk("model 96*96", mont_ref(64'd96, 64'd96, 64'd97, 8), 64'd36);

      // Basic products.
      or_mode = 0;
      issue(0, 64'd5, 64'd7, 64'd97);
      wait_done(0);
      chk("basic 5*7 result", 64'(bus8.result), 64'd96);
      issue(0, 64'd1, 64'd1, 64'd97);
      issue(0, 64'd62, 64'd50, 64'd97);
      issue(0, 64'd0, 64'd55, 64'd97);
      wait_done(0);

      // Back-pressure: result held 20 cycles in DONE.
      or_mode = 2;
      issue(0, 64'd96, 64'd96, 64'd97);
      repeat (30) @(negedge clk);
      chk("bp out_valid", 64'(bus8.out_valid), 64'd1);
      chk("bp result", 64'(bus8.result), 64'd36);
      chk("bp in_ready", 64'(bus8.in_ready), 64'd0);
      or_mode = 0;
      wait_done(0);
      chk("bp in_ready after", 64'(bus8.in_ready), 64'd1);

      // 64-bit near-maximal modulus, then six back-to-back operations.
      issue(1, 64'hFFFF_FFFF_FFFF_FFC4, 64'd1, 64'hFFFF_FFFF_FFFF_FFC5);
      wait_done(1);
      acc64_q.delete();
      for (int k = 0; k < 6; k++) rand_op(1);
      wait_done(1);
      chk("b2b count", 64'(acc64_q.size()), 64'd6);
      for (int k = 1; k < acc64_q.size(); k++)
         chk("b2b interval", 64'(acc64_q[k] - acc64_q[k-1]), 64'd67);

      // Reset during CALC discards the operation.
      issue(0, 64'd5, 64'd7, 64'd97);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready", 64'(bus8.in_ready), 64'd1);
      for (int k = 0; k < 12; k++) begin
         chk("post-rst out_valid", 64'(bus8.out_valid), 64'd0);
         @(negedge clk);
      end
      issue(0, 64'd5, 64'd7, 64'd97);
      wait_done(0);
      chk("post-rst 5*7", 64'(bus8.result), 64'd96);

      // Operand ports scrambled while busy.
      issue(0, 64'd23, 64'd88, 64'd97);
      for (int g = 0; busy8 && g < 50; g++) begin
         bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.n = 8'($urandom);
         @(negedge clk);
      end
      wait_done(0);
      issue(1, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 64'hF000_0000_0000_0001);
      for (int g = 0; busy64 && g < 200; g++) begin
         bus64.a = {$urandom, $urandom}; bus64.b = {$urandom, $urandom}; bus64.n = {$urandom, $urandom};
         @(negedge clk);
      end
      wait_done(1);

      // Illegal operands: rejected with err in the range-check build,
      // otherwise full latency with err=0.
      issue(0, 64'd5, 64'd7, 64'd96);
      issue(0, 64'd97, 64'd3, 64'd97);
      issue(0, 64'd3, 64'd200, 64'd97);
      wait_done(0);

      // Randomized traffic with random back-pressure on both widths.
      or_mode = 1;
      fork
         for (int k = 0; k < 40; k++) rand_op(0);
         for (int k = 0; k < 12; k++) rand_op(1);
      join
      wait_done(0);
      wait_done(1);
      or_mode = 0;
      repeat (2) @(negedge clk);
      chk("final queue8", 64'(exp8_q.size()), 64'd0);
      chk("final queue64", 64'(exp64_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/montgomery_mul_seq.md
# montgomery_mul_seq

Parametrised, handshaked successor to `montgomery_top`. It computes the Montgomery product result = a·b·R⁻¹ mod n, with R = 2^WIDTH, using a bit-serial radix-2 datapath. It has a runtime modulus, valid/ready on both sides, a synchronous reset and an explicit done/err indication. It sits between the operand sequencer and the modular-exponentiation controller.

## Interface
- `WIDTH`, default 64: operand, modulus and result width in bits; must be ≥ 4.
- `clk` in, 1: rising-edge clock.
- `rst` in, 1: synchronous, active-high reset.
- `in_valid` in, 1: a, b and n are valid.
- `in_ready` out, 1: block can accept an operation.
- `a` in, WIDTH: multiplicand; must be < n.
- `b` in, WIDTH: multiplier; must be < n.
- `n` in, WIDTH: modulus; must be odd.
- `out_valid` out, 1: result and err are valid.
- `out_ready` in, 1: consumer accepts the result.
- `result` out, WIDTH: Montgomery product, always < n for legal inputs.
- `err` out, 1: operation was rejected (range-check build only).

## Operation
- State machine states:
  - IDLE: in_ready=1. `in_valid & in_ready` latches a, b and n into internal registers, clears S (WIDTH+2 bits) and the bit counter i, then goes to CALC.
  - CALC: one iteration per cycle, for i = 0..WIDTH-1:
    - T = S + (a[i] ? b : 0)
    - if T[0], T = T + n
    - S = T >> 1
    - After the iteration with i = WIDTH-1, go to FINAL.
  - FINAL: result ← (S ≥ n) ? S − n : S, truncated to WIDTH bits; out_valid ← 1; go to DONE.
  - DONE: result, err and out_valid are held stable. `out_valid & out_ready` clears out_valid and returns to IDLE.
- Arithmetic and input handling:
  - The intermediate S never exceeds 2n, so WIDTH+2 bits is sufficient; there is no overflow at WIDTH = 64 with n close to 2^64.
  - Port values of a, b and n are ignored outside the IDLE acceptance cycle. Changing them mid-operation has no effect.
- Reset:
  - rst in any state forces IDLE. It also gives out_valid=0, result=0, err=0, S=0, i=0.
  - An in-flight operation is discarded and no result is produced.
  - in_ready is 0 during the rst cycle and 1 on the first cycle after rst deasserts.
- Legal inputs (without range check): illegal inputs (n even, a ≥ n or b ≥ n) give an unspecified result, but the block still completes with normal timing. It never hangs.

## Timing
- Handshake and latency:
  - Acceptance edge = E0.
  - CALC occupies edges E1..E_WIDTH.
  - FINAL is edge E_WIDTH+1.
  - out_valid is high from the cycle after E_WIDTH+1. Latency = WIDTH+1 clock edges from acceptance.
- Throughput:
  - in_ready=0 from the cycle after E0 until the cycle after the output handshake.
  - Minimum initiation interval is WIDTH+3 cycles, reached when out_ready is held high.
- No combinational path exists from inputs to outputs. in_ready and out_valid are decoded from registered state only.
- out_ready may be held low indefinitely; DONE waits with all outputs stable.
- in_valid asserted while in_ready=0 is ignored and is not queued.

## Configuration
- Macro: `MONTGOMERY_RANGE_CHECK_EN`.
- Defined:
  - At acceptance, the block checks n[0]==0, a ≥ n and b ≥ n.
  - If any check is true, it skips CALC and FINAL and goes directly to DONE with result=0 and err=1.
  - out_valid rises in the cycle after E0 (latency 1).
  - Legal operations behave as above, with err=0.
- Undefined:
  - No comparators are instantiated and err is tied to 0.
  - All operations take the full WIDTH+1 latency.

## Test plan
- Basic products, WIDTH=8, n=97 (R mod 97 = 62, R⁻¹ = 36):
  - a=5, b=7 → result=96.
  - a=1, b=1 → result=36.
  - a=62, b=50 → result=50.
  - a=0, b=55 → result=0.
  - Each result has out_valid rising exactly 9 edges after acceptance.
- Back-pressure, WIDTH=8, n=97, a=96, b=96:
  - Hold out_ready=0 for 20 cycles → result=36 stays stable and in_ready stays 0.
  - Release out_ready → returns to IDLE and in_ready=1 the next cycle.
- WIDTH=64, n=2^64−59:
  - a=2^64−60, b=1 → result equals the golden model a·R⁻¹ mod n.
  - Six back-to-back operations with out_ready=1 → each completes with an initiation interval of 67 cycles.
- Reset mid-CALC, WIDTH=8:
  - Assert rst 4 cycles after acceptance → out_valid never rises and in_ready=1 on the cycle after rst drops.
  - A subsequent operation a=5, b=7, n=97 → result=96.
- Input stability:
  - Change a, b and n on every cycle during CALC → the result matches the operands latched at acceptance.
- Range check (macro defined), WIDTH=8:
  - n=96 → err=1, result=0, out_valid one cycle after acceptance.
  - a=97, n=97 → same response.
  - Macro undefined → err remains 0 for all cases.
